mem_access_unit: RTL

Initiator side of the data-memory interface, sitting in the MEM stage between the pipeline and the 64-word data memory. It accepts one load or store request per transaction over a valid/ready handshake, sequences the memory's memrd/memwr/address/data lines, and returns load data or store completion. It supports byte, halfword and word accesses; sub-word stores are performed by read-modify-write.

---
 rtl/mem_access_unit.sv | 119 +++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Data-memory initiator for the MEM stage. It sequences loads and stores into a
// 64x32 word-addressed memory and performs sub-word stores by read-modify-write.
module mem_access_unit (
  input  logic        clk,
  input  logic        res,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [7:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        memwr,
  output logic        memrd,
  output logic [5:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_e;

  state_e      state_q, state_d;
  logic        we_q, sign_q, err_q;
  logic [1:0]  size_q, off_q;
  logic [31:0] wdata_q, rdata_q, mem_wdata_q;
  logic [5:0]  mem_addr_q;

  logic        req_err, word_st;
  logic [4:0]  shamt;
  logic [31:0] lane, ext, mask, merged;

  assign req_err = (req_size == 2'b11) ||
                   (req_size == 2'b01 && req_addr[0]) ||
                   (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  assign word_st = req_we && (req_size == 2'b10);

  // Lane handling works on the latched offset; CAP is the only consumer.
  assign shamt  = {off_q, 3'b000};
  assign lane   = mem_rdata >> shamt;
  assign mask   = ((size_q == 2'b00) ? 32'h0000_00ff : 32'h0000_ffff) << shamt;
  assign merged = (mem_rdata & ~mask) | ((wdata_q << shamt) & mask);

  always_comb begin
    ext = mem_rdata;
    case (size_q)
      2'b00:   ext = {{24{sign_q & lane[7]}},  lane[7:0]};
      2'b01:   ext = {{16{sign_q & lane[15]}}, lane[15:0]};
      default: ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    memrd      = 1'b0;
    memwr      = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)      state_d = DONE;
          else if (word_st) state_d = WR;
          else              state_d = RD;
        end
      end
      RD:   begin memrd = 1'b1; state_d = CAP; end
      CAP:  state_d = we_q ? WR : DONE;
      WR:   begin memwr = 1'b1; state_d = DONE; end
      DONE: begin resp_valid = 1'b1; state_d = IDLE; end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      sign_q      <= 1'b0;
      err_q       <= 1'b0;
      size_q      <= 2'b00;
      off_q       <= 2'b00;
      wdata_q     <= '0;
      rdata_q     <= '0;
      mem_wdata_q <= '0;
      mem_addr_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (req_valid) begin
          we_q    <= req_we;
          sign_q  <= req_signed;
          size_q  <= req_size;
          off_q   <= req_addr[1:0];
          wdata_q <= req_wdata;
          err_q   <= req_err;
          // Stores and errors report zero data; loads overwrite it in CAP.
          if (req_err || req_we) rdata_q <= '0;
          if (!req_err)          mem_addr_q <= req_addr[7:2];
          if (!req_err && word_st) mem_wdata_q <= req_wdata;
        end
        CAP: begin
          if (we_q) mem_wdata_q <= merged;
          else      rdata_q     <= ext;
        end
        default: ;
      endcase
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule
